shifter_pipe: RTL and testbench
===============================

# shifter_pipe

Parametrised, pipelined barrel shifter that generalises the 16-bit combinational SLL/SRA/ROR shifter to any power-of-two width. It also adds a logical-right mode, result flags, and an elastic valid/ready handshake on both sides. It sits between operand fetch and writeback in the ALU datapath. It accepts one operation per cycle and returns results in order after a fixed pipeline latency, with full backpressure support.

## Interface
Parameters:
- WIDTH, 16, data width; must be a power of two, minimum 4.
- SHW, $clog2(WIDTH), shift-amount width and number of pipeline stages. Derived; do not override.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- in_valid  input  1  operation offered this cycle.
- in_ready  output  1  shifter accepts the offered operation this cycle.
- in_data  input  WIDTH  operand.
- in_mode  input  2  operation: 00 SLL, 01 SRA, 10 ROR, 11 see Configuration.
- in_amt  input  SHW  shift amount, 0 to WIDTH-1.
- out_valid  output  1  result present.
- out_ready  input  1  consumer takes the result this cycle.
- out_data  output  WIDTH  shifted result.
- out_zero  output  1  out_data == 0.
- out_neg  output  1  out_data[WIDTH-1].

## Operation
- The pipeline has SHW register stages, numbered 0 to SHW-1.
- Stage k holds:
  - valid_k
  - data_k
  - mode_k
  - the remaining amount bits amt_k[SHW-1:k+1]
- Stage k applies a shift of 2^k when amount bit k is 1. Otherwise data passes unchanged.
- Stage 0 applies bit 0 to in_data at acceptance.
- Per-step behaviour by mode, for a shift of s:
  - SLL: shift left, zero fill.
  - SRA: shift right, fill with bit WIDTH-1 of the step's input.
  - ROR: bits shifted out of bit 0 re-enter at bit WIDTH-1.
- Mode and amount travel with the data, so operations with different modes coexist in the pipe.
- in_amt = 0 returns in_data unchanged in every mode.
- The stage order is fixed ascending (1, 2, 4, ...). The final result equals a single shift by in_amt in all modes.
- Output flags are combinational from stage SHW-1 data. They are meaningful only while out_valid = 1.

## Timing
- Reset (rst_n low, asynchronous) clears all valid_k, data_k, mode_k and amt_k to 0.
- Output values during and after reset:
  - out_valid = 0
  - out_data = 0
  - out_zero = 1
  - out_neg = 0
  - in_ready = 1 once rst_n is high.
- Reset asserted mid-operation discards every in-flight operation. No partial result appears.
- Acceptance occurs on a rising edge with in_valid && in_ready.
- Latency: a result accepted at edge N is presented with out_valid = 1 after edge N+SHW-1. For WIDTH=16 that is the 4th edge after acceptance, counting the acceptance edge as the 1st.
- Throughput is one operation per cycle when out_ready is held high.
- Stage advance rule: stage k loads from stage k-1 (or from the input, for k = 0) when !valid_k || adv_{k+1}. The last stage uses out_ready in place of adv_{k+1}.
- in_ready = !valid_0 || adv_1. This is combinational from out_ready through the stage chain. No registered skid buffer.
- A stage whose predecessor is empty but which advances clears its valid bit.
- When out_valid = 1 and out_ready = 0, out_data and the flags hold stable. No stage with valid set changes contents.
- When the pipe is full and stalled, in_ready = 0.
- Acceptance and output handoff in the same cycle shift the whole pipe by one stage and lose no operation.
- in_data, in_mode and in_amt are don't-care when in_valid = 0.

## Configuration
- Macro: SHIFTER_PIPE_SRL_EN.
- Defined: mode 11 is logical shift right (SRL), zero fill from bit WIDTH-1.
- Undefined: mode 11 passes the operand through unchanged regardless of in_amt. out_data = in_data, and the operation still incurs full latency and occupies a slot.
- The macro changes no port, parameter or latency.

## Test plan
- **Reset:** assert rst_n low mid-stream with 4 operations in flight, then release.
  - Required: out_valid = 0, out_data = 0, out_zero = 1, in_ready = 1.
  - Required: no stale result ever emerges.
- **Basic modes (WIDTH=16, out_ready = 1):**
  - SLL 0x8001 by 1 -> 0x0002.
  - SRA 0x8000 by 15 -> 0xFFFF, out_neg = 1.
  - ROR 0x0001 by 1 -> 0x8000.
  - Each arrives exactly 4 cycles after acceptance.
- **Back-to-back throughput:** issue 16 consecutive ROR operations of 0x1234 by amounts 0 to 15.
  - Required: 16 consecutive out_valid cycles in order.
  - Amount 4 -> 0x4123; amount 8 -> 0x3412.
- **Backpressure:** issue 6 operations while holding out_ready = 0.
  - Required: in_ready drops after exactly 4 acceptances.
  - Required: out_data holds the first result.
  - Releasing out_ready drains all 6 in order with none lost or duplicated.
- **Mode 11 and flags:** 0x8000 by 15.
  - With SHIFTER_PIPE_SRL_EN: 0x0001, out_zero = 0.
  - Without: 0x8000, out_neg = 1.
  - SLL 0x0001 by 0 -> 0x0001; SLL 0x8000 by 1 -> 0x0000, out_zero = 1.
- **Width scaling (WIDTH=32, latency 5):**
  - SRA 0x80000000 by 31 -> 0xFFFFFFFF.
  - ROR 0x00000001 by 31 -> 0x00000002.

Source files
------------

// File: rtl/shifter_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : shifter_pipe
//  Description : Pipelined barrel shifter with a valid/ready handshake on both
//                sides. Stage k shifts by 2^k when amount bit k is set, so
//                there are SHW = log2(WIDTH) register stages. Mode and the
//                not-yet-consumed amount bits travel with the data, which lets
//                different operations share the pipe. Results come out in
//                order.
//  Modes       : 00 SLL, 01 SRA, 10 ROR,
//                11 SRL when SHIFTER_PIPE_SRL_EN is defined, otherwise the
//                operand passes through unchanged (full latency, one slot).
//  Macro       : SHIFTER_PIPE_SRL_EN (optional; changes mode 11 only).
//  Ports       : clk        - clock, rising edge
//                rst_n      - asynchronous active-low reset
//                in_valid   - operation offered
//                in_ready   - operation accepted this cycle
//                in_data    - operand [WIDTH-1:0]
//                in_mode    - operation select [1:0]
//                in_amt     - shift amount [SHW-1:0]
//                out_valid  - result present
//                out_ready  - consumer takes the result
//                out_data   - result [WIDTH-1:0]
//                out_zero   - out_data == 0
//                out_neg    - out_data[WIDTH-1]
//  Revision    : 1.0 - initial release
// ============================================================================
module shifter_pipe #(
    parameter int WIDTH = 16,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [1:0]       in_mode,
    input  logic [SHW-1:0]   in_amt,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_zero,
    output logic             out_neg
);

    localparam logic [1:0] c_MODE_SLL = 2'b00;
    localparam logic [1:0] c_MODE_SRA = 2'b01;
    localparam logic [1:0] c_MODE_ROR = 2'b10;
    localparam logic [1:0] c_MODE_X11 = 2'b11;

    // One conditional power-of-two step. SRA fills with the MSB of this
    // step's input; chaining the ascending steps gives the full shift.
    function automatic logic [WIDTH-1:0] f_step(
        input logic [WIDTH-1:0] d,
        input logic [1:0]       mode,
        input logic             en,
        input int unsigned      s
    );
        logic [WIDTH-1:0] r;
        r = d;
        if (en) begin
            case (mode)
                c_MODE_SLL: r = d << s;
                c_MODE_SRA: r = (d >> s) | ({WIDTH{d[WIDTH-1]}} & ~({WIDTH{1'b1}} >> s));
                c_MODE_ROR: r = (d >> s) | (d << (WIDTH - s));
`ifdef SHIFTER_PIPE_SRL_EN
                c_MODE_X11: r = d >> s;
`else
                c_MODE_X11: r = d;
`endif
                default:    r = d;
            endcase
        end
        return r;
    endfunction

    genvar k;
    generate
        for (k = 0; k < SHW; k++) begin : g_stage
            logic             v_q;
            logic             v_d;
            logic [WIDTH-1:0] d_q;
            logic [WIDTH-1:0] d_d;
            logic             adv;      // this stage loads on the next edge
            logic             src_v;
            logic [WIDTH-1:0] src_d;
            logic [1:0]       src_m;
            logic             src_bit;  // amount bit k for the incoming op

            if (k == 0) begin : g_src_in
                assign src_v   = in_valid;
                assign src_d   = in_data;
                assign src_m   = in_mode;
                assign src_bit = in_amt[0];
            end else begin : g_src_prev
                assign src_v   = g_stage[k-1].v_q;
                assign src_d   = g_stage[k-1].d_q;
                assign src_m   = g_stage[k-1].g_fwd.m_q;
                assign src_bit = g_stage[k-1].g_fwd.a_q[k];
            end

            // A stage may load when it is empty or when its content moves on;
            // the chain runs combinationally back from out_ready.
            if (k == SHW - 1) begin : g_adv_last
                assign adv = !v_q || out_ready;
            end else begin : g_adv_mid
                assign adv = !v_q || g_stage[k+1].adv;
            end

            always_comb begin
                v_d = v_q;
                d_d = d_q;
                if (adv) begin
                    v_d = src_v;
                    if (src_v) begin
                        d_d = f_step(src_d, src_m, src_bit, 1 << k);
                    end
                end
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    v_q <= 1'b0;
                    d_q <= '0;
                end else begin
                    v_q <= v_d;
                    d_q <= d_d;
                end
            end

            // Mode and remaining amount bits are only needed by later stages,
            // so the last stage carries neither.
            if (k < SHW - 1) begin : g_fwd
                logic [1:0]       m_q;
                logic [1:0]       m_d;
                logic [SHW-1:k+1] a_q;
                logic [SHW-1:k+1] a_d;
                logic [SHW-1:k+1] src_a;

                if (k == 0) begin : g_amt_in
                    assign src_a = in_amt[SHW-1:1];
                end else begin : g_amt_prev
                    assign src_a = g_stage[k-1].g_fwd.a_q[SHW-1:k+1];
                end

                always_comb begin
                    m_d = m_q;
                    a_d = a_q;
                    if (adv && src_v) begin
                        m_d = src_m;
                        a_d = src_a;
                    end
                end

                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n) begin
                        m_q <= 2'b00;
                        a_q <= '0;
                    end else begin
                        m_q <= m_d;
                        a_q <= a_d;
                    end
                end
            end
        end
    endgenerate

    assign in_ready  = g_stage[0].adv;
    assign out_valid = g_stage[SHW-1].v_q;
    assign out_data  = g_stage[SHW-1].d_q;
    assign out_zero  = ~|out_data;
    assign out_neg   = out_data[WIDTH-1];

endmodule
`default_nettype wire

// File: tb/tb_shifter_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : tb_shifter_pipe
//  Description : Self-checking bench for shifter_pipe. A WIDTH=16 instance is
//                checked through an in-order scoreboard; a WIDTH=32 instance
//                is checked with directed single operations.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_shifter_pipe;

    localparam int c_W = 16;
    localparam int c_S = 4;

`ifdef SHIFTER_PIPE_SRL_EN
    localparam logic [15:0] c_M11_EXP = 16'h0001;
`else
    localparam logic [15:0] c_M11_EXP = 16'h8000;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_data;
    logic [1:0]  in_mode;
    logic [3:0]  in_amt;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
    logic        out_zero;
    logic        out_neg;

    logic        b_in_valid;
    logic        b_in_ready;
    logic [31:0] b_in_data;
    logic [1:0]  b_in_mode;
    logic [4:0]  b_in_amt;
    logic        b_out_valid;
    logic        b_out_ready;
    logic [31:0] b_out_data;
    logic        b_out_zero;
    logic        b_out_neg;

    always #5 clk = ~clk;

    shifter_pipe #(.WIDTH(c_W)) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_mode   (in_mode),
        .in_amt    (in_amt),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_zero  (out_zero),
        .out_neg   (out_neg)
    );

    shifter_pipe #(.WIDTH(32)) u_dut32 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (b_in_valid),
        .in_ready  (b_in_ready),
        .in_data   (b_in_data),
        .in_mode   (b_in_mode),
        .in_amt    (b_in_amt),
        .out_valid (b_out_valid),
        .out_ready (b_out_ready),
        .out_data  (b_out_data),
        .out_zero  (b_out_zero),
        .out_neg   (b_out_neg)
    );

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    endtask

    // Reference: a single shift by the whole amount.
    function automatic logic [15:0] ref16(input logic [15:0] d, input logic [1:0] m,
                                          input logic [3:0] a);
        logic [31:0] dd;
        logic [15:0] r;
        case (m)
            2'b00: r = d << a;
            2'b01: r = $signed(d) >>> a;
            2'b10: begin
                dd = {d, d} >> a;
                r  = dd[15:0];
            end
            default: begin
`ifdef SHIFTER_PIPE_SRL_EN
                r = d >> a;
`else
                r = d;
`endif
            end
        endcase
        return r;
    endfunction

    typedef struct {
        logic [15:0] d;
        int          cyc;
        bit          lat;
    } exp_t;

    exp_t        sb[$];
    exp_t        mon_e;
    logic [15:0] cur_exp = '0;
    bit          cur_lat = 1'b0;
    int          cyc     = 0;
    int          run     = 0;
    int          max_run = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard monitor, sampled mid-cycle.
    always @(negedge clk) begin
        if (!rst_n) begin
            sb.delete();
            run = 0;
        end else begin
            if (out_valid) run++;
            else run = 0;
            if (run > max_run) max_run = run;
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    chk("stale_out", {63'd0, out_valid}, 64'd0);
                end else begin
                    mon_e = sb.pop_front();
                    chk("out_data", {48'd0, out_data}, {48'd0, mon_e.d});
                    chk("out_zero", {63'd0, out_zero}, {63'd0, mon_e.d == 16'h0});
                    chk("out_neg",  {63'd0, out_neg},  {63'd0, mon_e.d[15]});
                    if (mon_e.lat) chk("latency", 64'(cyc - mon_e.cyc), 64'(c_S));
                end
            end
            if (in_valid && in_ready) sb.push_back('{cur_exp, cyc, cur_lat});
        end
    end

    task automatic send(input logic [15:0] d, input logic [1:0] m, input logic [3:0] a,
                        input logic [15:0] exp, input bit lat, output int waited);
        cur_exp  = exp;
        cur_lat  = lat;
        in_data  = d;
        in_mode  = m;
        in_amt   = a;
        in_valid = 1'b1;
        waited   = 0;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            waited++;
            if (waited > 200) begin
                chk("send_timeout", {63'd0, in_ready}, 64'd1);
                break;
            end
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send32(input string tag, input logic [31:0] d, input logic [1:0] m,
                          input logic [4:0] a, input logic [31:0] exp);
        int n;
        b_in_data  = d;
        b_in_mode  = m;
        b_in_amt   = a;
        b_in_valid = 1'b1;
        @(negedge clk);
        chk({tag, "_in_ready"}, {63'd0, b_in_ready}, 64'd1);
        @(posedge clk);
        #1;
        b_in_valid = 1'b0;
        n = 1;   // the acceptance edge counts as the first
        forever begin
            @(negedge clk);
            if (b_out_valid || n > 50) break;
            @(posedge clk);
            n++;
        end
        chk({tag, "_lat"},  64'(n), 64'd5);
        chk({tag, "_data"}, {32'd0, b_out_data}, {32'd0, exp});
        idle(2);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    logic [15:0] bp_exp [6];
    logic [15:0] e16;
    int          w;
    bit          seen;

    initial begin
        rst_n       = 1'b0;
        in_valid    = 1'b0;
        in_data     = '0;
        in_mode     = '0;
        in_amt      = '0;
        out_ready   = 1'b1;
        b_in_valid  = 1'b0;
        b_in_data   = '0;
        b_in_mode   = '0;
        b_in_amt    = '0;
        b_out_ready = 1'b1;

        // Power-on reset state
        #12;
        chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_out_data",  {48'd0, out_data},  64'd0);
        chk("rst_out_zero",  {63'd0, out_zero},  64'd1);
        chk("rst_out_neg",   {63'd0, out_neg},   64'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
        idle(1);

        // Basic modes, issued back to back so modes mix in the pipe
        send(16'h8001, 2'b00, 4'd1,  16'h0002,  1'b1, w);
        send(16'h8000, 2'b01, 4'd15, 16'hFFFF,  1'b1, w);
        send(16'h0001, 2'b10, 4'd1,  16'h8000,  1'b1, w);
        send(16'h8000, 2'b11, 4'd15, c_M11_EXP, 1'b1, w);
        send(16'h0001, 2'b00, 4'd0,  16'h0001,  1'b1, w);
        send(16'h8000, 2'b00, 4'd1,  16'h0000,  1'b1, w);
        send(16'h4000, 2'b01, 4'd3,  16'h0800,  1'b1, w);
        send(16'hA5C3, 2'b11, 4'd0,  16'hA5C3,  1'b1, w);
        idle(8);

        // Back-to-back throughput
        max_run = 0;
        for (int a = 0; a < 16; a++) begin
            if (a == 4)      e16 = 16'h4123;
            else if (a == 8) e16 = 16'h3412;
            else             e16 = ref16(16'h1234, 2'b10, 4'(a));
            send(16'h1234, 2'b10, 4'(a), e16, 1'b1, w);
            chk("tput_no_wait", 64'(w), 64'd0);
        end
        idle(8);
        chk("tput_run", 64'(max_run), 64'd16);

        // Backpressure: pipe fills after exactly four acceptances
        out_ready = 1'b0;
        for (int i = 0; i < 6; i++)
            bp_exp[i] = ref16(16'h00F0 + 16'(i), 2'(i % 3), 4'(i + 2));
        for (int i = 0; i < 4; i++) begin
            send(16'h00F0 + 16'(i), 2'(i % 3), 4'(i + 2), bp_exp[i], 1'b0, w);
            chk("bp_accept_no_wait", 64'(w), 64'd0);
        end
        cur_exp  = bp_exp[4];
        cur_lat  = 1'b0;
        in_data  = 16'h00F4;
        in_mode  = 2'(4 % 3);
        in_amt   = 4'd6;
        in_valid = 1'b1;
        for (int t = 0; t < 3; t++) begin
            @(negedge clk);
            chk("bp_in_ready_low", {63'd0, in_ready},  64'd0);
            chk("bp_out_valid",    {63'd0, out_valid}, 64'd1);
            chk("bp_hold_first",   {48'd0, out_data},  {48'd0, bp_exp[0]});
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        send(16'h00F4, 2'(4 % 3), 4'd6, bp_exp[4], 1'b0, w);
        send(16'h00F5, 2'(5 % 3), 4'd7, bp_exp[5], 1'b0, w);
        idle(10);
        chk("bp_drained", 64'(sb.size()), 64'd0);

        // Reset with four operations in flight
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++)
            send(16'h1111 * 16'(i + 1), 2'b00, 4'(i), 16'hDEAD, 1'b0, w);
        rst_n = 1'b0;
        #2;
        chk("rstmid_out_valid", {63'd0, out_valid}, 64'd0);
        chk("rstmid_out_data",  {48'd0, out_data},  64'd0);
        chk("rstmid_out_zero",  {63'd0, out_zero},  64'd1);
        chk("rstmid_out_neg",   {63'd0, out_neg},   64'd0);
        @(posedge clk);
        #1;
        rst_n     = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        chk("rstmid_in_ready", {63'd0, in_ready}, 64'd1);
        seen = 1'b0;
        repeat (10) begin
            @(negedge clk);
            seen = seen | out_valid;
        end
        chk("rstmid_no_stale", {63'd0, seen}, 64'd0);
        @(posedge clk);
        #1;
        send(16'h00FF, 2'b00, 4'd4, 16'h0FF0, 1'b1, w);
        idle(8);

        // Width scaling
        send32("w32_sra", 32'h8000_0000, 2'b01, 5'd31, 32'hFFFF_FFFF);
        send32("w32_ror", 32'h0000_0001, 2'b10, 5'd31, 32'h0000_0002);
        send32("w32_sll", 32'h0000_0001, 2'b00, 5'd31, 32'h8000_0000);

        chk("sb_empty", 64'(sb.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
